issue_queue: RTL and testbench

Out-of-order issue queue directly upstream of the execute stage. It buffers dispatched instructions until both source operands are available, and captures operand values from the execute stage's result broadcast. Each cycle it issues the oldest ready entry, with operands and control payload, into the execute stage's input registers. A branch/jump flush from execute empties the queue.

---
 rtl/issue_queue.sv | 139 +++++++++++++
 tb/tb_issue_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Out-of-order issue queue: compacting array (entry 0 oldest) with operand capture
// from the execute broadcast, oldest-ready select and registered issue outputs.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int PW    = 48
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [5:0]               disp_srcA_map,
  input  logic [5:0]               disp_srcB_map,
  input  logic                     disp_srcA_rdy,
  input  logic                     disp_srcB_rdy,
  input  logic [31:0]              disp_srcA_val,
  input  logic [31:0]              disp_srcB_val,
  input  logic [5:0]               disp_dest_map,
  input  logic                     disp_regwr,
  input  logic [PW-1:0]            disp_payload,
  input  logic                     bc_flag,
  input  logic [5:0]               bc_map,
  input  logic [31:0]              bc_val,
  input  logic                     flush,
  output logic                     iss_valid,
  output logic [31:0]              iss_opA,
  output logic [31:0]              iss_opB,
  output logic [5:0]               iss_dest_map,
  output logic                     iss_regwr,
  output logic [PW-1:0]            iss_payload,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic          valid;
    logic          a_rdy;
    logic [5:0]    a_map;
    logic [31:0]   a_val;
    logic          b_rdy;
    logic [5:0]    b_map;
    logic [31:0]   b_val;
    logic [5:0]    dest_map;
    logic          regwr;
    logic [PW-1:0] payload;
  } entry_t;

  entry_t          ent     [DEPTH];
  entry_t          ent_nxt [DEPTH];
  entry_t          ent_ext [DEPTH+1];
  entry_t          disp_ent;
  logic            issue;
  logic            accept;
  logic [IW-1:0]   sel_idx;
  logic [CW-1:0]   widx;

  // Same capture rule serves both stored-entry wakeup and the dispatch bypass.
  function automatic entry_t wake(entry_t e, logic f, logic [5:0] m, logic [31:0] v);
    entry_t r;
    r = e;
    if (f && r.valid && !r.a_rdy && r.a_map == m) begin
      r.a_rdy = 1'b1;
      r.a_val = v;
    end
    if (f && r.valid && !r.b_rdy && r.b_map == m) begin
      r.b_rdy = 1'b1;
      r.b_val = v;
    end
    return r;
  endfunction

  assign disp_ready = (count < CW'(DEPTH));
  assign accept     = disp_valid && disp_ready;

  // Descending scan so the lowest ready index is the last one written.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    issue   = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (ent[i].valid && ent[i].a_rdy && ent[i].b_rdy) begin
        issue   = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  always_comb begin
    disp_ent = '{valid:    1'b1,
                 a_rdy:    disp_srcA_rdy, a_map: disp_srcA_map, a_val: disp_srcA_val,
                 b_rdy:    disp_srcB_rdy, b_map: disp_srcB_map, b_val: disp_srcB_val,
                 dest_map: disp_dest_map, regwr: disp_regwr,    payload: disp_payload};
    disp_ent = wake(disp_ent, bc_flag, bc_map, bc_val);
  end

  // Compact over the issued slot, wake stored sources, then append the dispatch.
  always_comb begin
    ent_ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) ent_ext[i] = ent[i];
    widx = count - CW'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt[i] = (issue && IW'(i) >= sel_idx) ? ent_ext[i+1] : ent_ext[i];
      ent_nxt[i] = wake(ent_nxt[i], bc_flag, bc_map, bc_val);
      if (accept && widx == CW'(i)) ent_nxt[i] = disp_ent;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      // NOTE: the entry array is reset in full so no stale operand survives a reset.
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count        <= '0;
      iss_valid    <= 1'b0;
      iss_opA      <= '0;
      iss_opB      <= '0;
      iss_dest_map <= '0;
      iss_regwr    <= 1'b0;
      iss_payload  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count     <= '0;
      iss_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
      count     <= count + CW'(accept) - CW'(issue);
      iss_valid <= issue;
      if (issue) begin
        iss_opA      <= ent[sel_idx].a_val;
        iss_opB      <= ent[sel_idx].b_val;
        iss_dest_map <= ent[sel_idx].dest_map;
        iss_regwr    <= ent[sel_idx].regwr;
        iss_payload  <= ent[sel_idx].payload;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios followed by random traffic,
// all compared against an in-order list model of the queue.
module tb_issue_queue;

  localparam int DEPTH = 8;
  localparam int PW    = 48;

  logic          CLK, RESET;
  logic          disp_valid, disp_ready;
  logic [5:0]    disp_srcA_map, disp_srcB_map, disp_dest_map;
  logic          disp_srcA_rdy, disp_srcB_rdy, disp_regwr;
  logic [31:0]   disp_srcA_val, disp_srcB_val;
  logic [PW-1:0] disp_payload;
  logic          bc_flag, flush;
  logic [5:0]    bc_map;
  logic [31:0]   bc_val;
  logic          iss_valid, iss_regwr;
  logic [31:0]   iss_opA, iss_opB;
  logic [5:0]    iss_dest_map;
  logic [PW-1:0] iss_payload;
  logic [3:0]    count;

  issue_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
    .CLK(CLK), .RESET(RESET),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_srcA_map(disp_srcA_map), .disp_srcB_map(disp_srcB_map),
    .disp_srcA_rdy(disp_srcA_rdy), .disp_srcB_rdy(disp_srcB_rdy),
    .disp_srcA_val(disp_srcA_val), .disp_srcB_val(disp_srcB_val),
    .disp_dest_map(disp_dest_map), .disp_regwr(disp_regwr), .disp_payload(disp_payload),
    .bc_flag(bc_flag), .bc_map(bc_map), .bc_val(bc_val), .flush(flush),
    .iss_valid(iss_valid), .iss_opA(iss_opA), .iss_opB(iss_opB),
    .iss_dest_map(iss_dest_map), .iss_regwr(iss_regwr), .iss_payload(iss_payload),
    .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic          a_rdy;
    logic [5:0]    a_map;
    logic [31:0]   a_val;
    logic          b_rdy;
    logic [5:0]    b_map;
    logic [31:0]   b_val;
    logic [5:0]    dest;
    logic          regwr;
    logic [PW-1:0] payload;
  } ins_t;

  ins_t          mq[$];
  logic          e_valid;
  logic [31:0]   e_opA, e_opB;
  logic [5:0]    e_dest;
  logic          e_regwr;
  logic [PW-1:0] e_payload;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_valid = 1'b0; e_opA = '0; e_opB = '0; e_dest = '0; e_regwr = 1'b0; e_payload = '0;
  endtask

  // One clock edge of the queue, stated as list operations on instructions in age order.
  task automatic model_edge();
    int   sz0, sel;
    ins_t t;
    if (!RESET) begin
      model_reset();
      return;
    end
    if (flush) begin
      mq.delete();
      e_valid = 1'b0;
      return;
    end
    sz0 = mq.size();
    sel = -1;
    for (int i = 0; i < mq.size(); i++)
      if (sel < 0 && mq[i].a_rdy && mq[i].b_rdy) sel = i;
    e_valid = (sel >= 0);
    if (sel >= 0) begin
      e_opA = mq[sel].a_val; e_opB = mq[sel].b_val; e_dest = mq[sel].dest;
      e_regwr = mq[sel].regwr; e_payload = mq[sel].payload;
      mq.delete(sel);
    end
    if (bc_flag) begin
      for (int i = 0; i < mq.size(); i++) begin
        t = mq[i];
        if (!t.a_rdy && t.a_map == bc_map) begin t.a_rdy = 1'b1; t.a_val = bc_val; end
        if (!t.b_rdy && t.b_map == bc_map) begin t.b_rdy = 1'b1; t.b_val = bc_val; end
        mq[i] = t;
      end
    end
    if (disp_valid && sz0 < DEPTH) begin
      t = '{disp_srcA_rdy, disp_srcA_map, disp_srcA_val, disp_srcB_rdy, disp_srcB_map,
            disp_srcB_val, disp_dest_map, disp_regwr, disp_payload};
      if (bc_flag && !t.a_rdy && t.a_map == bc_map) begin t.a_rdy = 1'b1; t.a_val = bc_val; end
      if (bc_flag && !t.b_rdy && t.b_map == bc_map) begin t.b_rdy = 1'b1; t.b_val = bc_val; end
      mq.push_back(t);
    end
  endtask

  task automatic check_outputs();
    check("iss_valid",    iss_valid,    e_valid);
    check("count",        count,        mq.size());
    check("iss_opA",      iss_opA,      e_opA);
    check("iss_opB",      iss_opB,      e_opB);
    check("iss_dest_map", iss_dest_map, e_dest);
    check("iss_regwr",    iss_regwr,    e_regwr);
    check("iss_payload",  iss_payload,  e_payload);
  endtask

  task automatic quiet();
    disp_valid = 1'b0; disp_srcA_map = '0; disp_srcB_map = '0; disp_srcA_rdy = 1'b0;
    disp_srcB_rdy = 1'b0; disp_srcA_val = '0; disp_srcB_val = '0; disp_dest_map = '0;
    disp_regwr = 1'b0; disp_payload = '0; bc_flag = 1'b0; bc_map = '0; bc_val = '0;
    flush = 1'b0;
  endtask

  task automatic set_disp(input logic ar, input logic [5:0] am, input logic [31:0] av,
                          input logic br, input logic [5:0] bm, input logic [31:0] bv,
                          input logic [5:0] dest, input logic [PW-1:0] pl);
    disp_valid = 1'b1;
    disp_srcA_rdy = ar; disp_srcA_map = am; disp_srcA_val = av;
    disp_srcB_rdy = br; disp_srcB_map = bm; disp_srcB_val = bv;
    disp_dest_map = dest; disp_regwr = 1'b1; disp_payload = pl;
  endtask

  task automatic set_bc(input logic [5:0] m, input logic [31:0] v);
    bc_flag = 1'b1; bc_map = m; bc_val = v;
  endtask

  // Inputs are applied 1 time unit after a rising edge and held until the next one.
  task automatic step();
    check("disp_ready", disp_ready, mq.size() < DEPTH);
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
    quiet();
  endtask

  initial begin
    logic [63:0] r;
    RESET = 1'b0;
    quiet();
    model_reset();
    #12;
    check_outputs();
    check("reset_disp_ready", disp_ready, 1'b1);
    @(negedge CLK);
    RESET = 1'b1;

    // Minimum latency: fully ready instruction issues one edge after dispatch.
    set_disp(1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 6'd12, 48'hA);
    step();
    step();
    check("A_valid", iss_valid, 1'b1);
    check("A_opA", iss_opA, 32'd5);
    check("A_opB", iss_opB, 32'd7);
    check("A_dest", iss_dest_map, 6'd12);
    check("A_count", count, 4'd0);

    // Younger ready instruction overtakes an older waiting one.
    set_disp(1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd1, 6'd13, 48'hB);
    step();
    set_disp(1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd3, 6'd14, 48'hC);
    step();
    step();
    check("Y_first", iss_dest_map, 6'd14);
    set_bc(6'd9, 32'hDEAD);
    step();
    check("X_not_same_edge", iss_valid, 1'b0);
    step();
    check("X_valid", iss_valid, 1'b1);
    check("X_opA", iss_opA, 32'hDEAD);
    check("X_dest", iss_dest_map, 6'd13);

    // Dispatch-time bypass of a same-cycle broadcast.
    set_disp(1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd4, 6'd15, 48'hD);
    set_bc(6'd3, 32'h11);
    step();
    step();
    check("bypass_valid", iss_valid, 1'b1);
    check("bypass_opA", iss_opA, 32'h11);

    // Fill to capacity; extra dispatches are refused.
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(1'b0, 6'(20 + i), 32'd0, 1'b1, 6'd0, 32'(i), 6'(16 + i), PW'(i));
      step();
    end
    check("full_count", count, 4'd8);
    check("full_ready", disp_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      set_disp(1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1, 6'd50, 48'hE);
      step();
    end
    check("full_ignored", iss_valid, 1'b0);
    set_bc(6'd22, 32'h22);
    step();
    check("full_still_blocked", disp_ready, 1'b0);
    step();
    check("wake2_dest", iss_dest_map, 6'd18);
    check("wake2_opA", iss_opA, 32'h22);
    check("ready_after_issue", disp_ready, 1'b1);

    // Flush drops held entries and a same-cycle dispatch.
    flush = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      set_disp(1'b0, 6'(30 + i), 32'd0, 1'b0, 6'(30 + i), 32'd0, 6'(30 + i), PW'(i));
      step();
    end
    check("pre_flush_count", count, 4'd5);
    set_disp(1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 32'd9, 6'd40, 48'hF);
    flush = 1'b1;
    step();
    check("flush_count", count, 4'd0);
    check("flush_valid", iss_valid, 1'b0);
    step();
    step();
    check("flush_dropped", iss_valid, 1'b0);

    // Asynchronous reset with an issue pending.
    for (int i = 0; i < 3; i++) begin
      set_disp(1'b0, 6'(50 + i), 32'd0, 1'b1, 6'd0, 32'd0, 6'(50 + i), PW'(i));
      step();
    end
    set_disp(1'b1, 6'd0, 32'h77, 1'b1, 6'd0, 32'h78, 6'd60, 48'h60);
    step();
    check("pre_reset_count", count, 4'd4);
    RESET = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("async_reset_ready", disp_ready, 1'b1);
    step();
    RESET = 1'b1;
    step();
    step();
    check("post_reset_valid", iss_valid, 1'b0);
    check("post_reset_count", count, 4'd0);

    // Random traffic over a small tag space so wakeups and bypasses are frequent.
    for (int n = 0; n < 600; n++) begin
      disp_valid    = ($urandom % 4) != 0;
      disp_srcA_rdy = $urandom % 2;
      disp_srcB_rdy = $urandom % 2;
      disp_srcA_map = 6'($urandom % 8);
      disp_srcB_map = 6'($urandom % 8);
      disp_srcA_val = $urandom;
      disp_srcB_val = $urandom;
      disp_dest_map = 6'($urandom % 64);
      disp_regwr    = $urandom % 2;
      r = {$urandom, $urandom};
      disp_payload  = r[PW-1:0];
      bc_flag       = $urandom % 2;
      bc_map        = 6'($urandom % 8);
      bc_val        = $urandom;
      flush         = ($urandom % 40) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
